// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM port arbiter: FSM state codes, grant encoding and
// default timing parameters.
package sram_arb_pkg;

  // FSM state codes
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRdAcc   = 3'd1;
  localparam logic [2:0] StWrSetup = 3'd2;
  localparam logic [2:0] StWrAcc   = 3'd3;
  localparam logic [2:0] StWrRecov = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;
  localparam logic [2:0] StHold    = 3'd6;

  // Grant encoding
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int unsigned DefaultWaitCycles = 1;
  localparam int unsigned DefaultLineWords  = 4;

endpackage

// File: rtl/sram_wait_timer.sv
// Wait-state down-counter: load sets the count, which then decrements to zero and holds.
// done is high while the count is zero, i.e. on the last cycle of an access.
module sram_wait_timer #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  output logic            done
);

  logic [CntW-1:0] cnt_q;

  // Load takes priority; otherwise count down and stick at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single asynchronous SRAM port between the icache refill path and the
// dcache path, sequences the SRAM strobes with programmable wait states, returns line
// reads word by word and closes each transaction with a one-cycle ready pulse.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LINE_WORDS  = DefaultLineWords,
  parameter int unsigned WAIT_CYCLES = DefaultWaitCycles
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic                          i_rvalid,
  output logic                          i_ready,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          d_rvalid,
  output logic                          d_ready,
  output logic [DATA_W-1:0]             rdata,
  output logic [$clog2(LINE_WORDS)-1:0] rword,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_dq_o,
  output logic                          sram_dq_oe,
  input  logic [DATA_W-1:0]             sram_dq_i,
  output logic                          sram_ce_n,
  output logic                          sram_oe_n,
  output logic                          sram_we_n
);

  localparam int unsigned    WordW    = $clog2(LINE_WORDS);
  localparam logic [WordW-1:0] LastWord = WordW'(LINE_WORDS - 1);
  localparam logic [2:0]     WaitVal  = 3'(WAIT_CYCLES);

  logic [2:0]        state_q, state_d;
  // gnt_q only changes on a new grant, so it doubles as the last-grant history.
  logic              gnt_q, gnt_sel;
  logic              grant_now;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WordW-1:0]  cnt_q;
  logic              timer_load, t_done, word_last, granted_req;
  // Capture stage: the word is sampled on its last access cycle and presented on
  // rdata/rvalid one cycle later, so back-to-back words never overwrite a live rdata.
  logic [DATA_W-1:0] cap_q, rdata_q;
  logic [WordW-1:0]  cap_idx_q, rword_q;
  logic              cap_vld_q, rvalid_q, ready_q;

  sram_wait_timer #(
    .CntW(3)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (WaitVal),
    .done     (t_done)
  );

  assign word_last   = (state_q == StRdAcc) && t_done;
  assign granted_req = (gnt_q == GNT_D) ? d_req : i_req;

  // Arbitration and next-state decode
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    grant_now  = 1'b0;
    gnt_sel    = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          grant_now  = 1'b1;
          timer_load = 1'b1;
          if (i_req && d_req) begin
            gnt_sel = (gnt_q == GNT_D) ? GNT_I : GNT_D;
          end else begin
            gnt_sel = d_req ? GNT_D : GNT_I;
          end
          state_d = ((gnt_sel == GNT_D) && d_we) ? StWrSetup : StRdAcc;
        end
      end
      StRdAcc: begin
        if (t_done) begin
          timer_load = 1'b1;
          if (cnt_q == LastWord) state_d = StDone;
        end
      end
      StWrSetup: begin
        timer_load = 1'b1;
        state_d    = StWrAcc;
      end
      StWrAcc: begin
        if (t_done) state_d = StWrRecov;
      end
      StWrRecov: state_d = StDone;
      // Hold off ready until the last read word has left the capture stage.
      StDone: begin
        if (!cap_vld_q) state_d = StHold;
      end
      StHold: begin
        if (!granted_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, grant/address latch, word counter and read-return pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      gnt_q     <= GNT_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      cap_idx_q <= '0;
      cap_vld_q <= 1'b0;
      rdata_q   <= '0;
      rword_q   <= '0;
      rvalid_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        gnt_q   <= gnt_sel;
        addr_q  <= (gnt_sel == GNT_D) ? d_addr : i_addr;
        wdata_q <= d_wdata;
        cnt_q   <= '0;
      end else if (word_last) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (word_last) begin
        cap_q     <= sram_dq_i;
        cap_idx_q <= cnt_q;
      end
      cap_vld_q <= word_last;
      if (cap_vld_q) begin
        rdata_q <= cap_q;
        rword_q <= cap_idx_q;
      end
      rvalid_q <= cap_vld_q;
      ready_q  <= (state_q == StDone) && !cap_vld_q;
    end
  end

  // SRAM strobes and requester-side outputs
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_addr  = addr_q;
    unique case (state_q)
      StRdAcc: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_addr = {addr_q[ADDR_W-1:WordW], cnt_q};
      end
      StWrSetup, StWrRecov: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      StWrAcc: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_dq_o = wdata_q;
  assign rdata     = rdata_q;
  assign rword     = rword_q;
  assign i_rvalid  = rvalid_q && (gnt_q == GNT_I);
  assign d_rvalid  = rvalid_q && (gnt_q == GNT_D);
  assign i_ready   = ready_q && (gnt_q == GNT_I);
  assign d_ready   = ready_q && (gnt_q == GNT_D);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: three instances (WAIT_CYCLES 0, 1, 3) share one stimulus
// set; each check observes one instance. SRAM read data is a pattern of the address.
module tb_sram_port_arbiter;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;

  logic          i_rvalid_v [3];
  logic          i_ready_v  [3];
  logic          d_rvalid_v [3];
  logic          d_ready_v  [3];
  logic [DW-1:0] rdata_v    [3];
  logic [1:0]    rword_v    [3];
  logic [AW-1:0] sram_addr_v[3];
  logic [DW-1:0] sram_dq_o_v[3];
  logic [DW-1:0] sram_dq_i_v[3];
  logic          dq_oe_v    [3];
  logic          ce_n_v     [3];
  logic          oe_n_v     [3];
  logic          we_n_v     [3];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {14'h0, a} ^ 32'hA5A5_0000;
  endfunction

  function automatic int wc_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_port_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .LINE_WORDS  (LW),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_rvalid   (i_rvalid_v[g]),
      .i_ready    (i_ready_v[g]),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rvalid   (d_rvalid_v[g]),
      .d_ready    (d_ready_v[g]),
      .rdata      (rdata_v[g]),
      .rword      (rword_v[g]),
      .sram_addr  (sram_addr_v[g]),
      .sram_dq_o  (sram_dq_o_v[g]),
      .sram_dq_oe (dq_oe_v[g]),
      .sram_dq_i  (sram_dq_i_v[g]),
      .sram_ce_n  (ce_n_v[g]),
      .sram_oe_n  (oe_n_v[g]),
      .sram_we_n  (we_n_v[g])
    );
    assign sram_dq_i_v[g] = pat(sram_addr_v[g]);
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for ready (t=%0t)", name, $time);
  endtask

  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            inst;
    int            exp_ready;  // cycles from grant edge to ready
    logic [AW-1:0] exp_base;   // first SRAM address of the access
    int            exp_rv;     // rvalid pulses expected
  } vec_t;

  vec_t vecs[7];

  // One transaction on instance v.inst: raise the request, follow every cycle from the
  // grant edge, then keep the request high to confirm no re-grant, then release.
  task automatic run_txn(input vec_t v);
    int  g, w, rv, we_cnt, oe_cnt;
    bit  seen, rvs, rdy, orv, ordy, is_rd;
    logic [AW-1:0] a;
    g = v.inst;
    w = wc_of(g);
    is_rd = !(v.is_d && v.we);
    @(negedge clk);
    if (v.is_d) begin
      d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
    end else begin
      i_addr = v.addr; i_req = 1'b1;
    end
    @(posedge clk);
    rv = 0; we_cnt = 0; oe_cnt = 0; seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      #1;
      rvs  = v.is_d ? d_rvalid_v[g] : i_rvalid_v[g];
      rdy  = v.is_d ? d_ready_v[g]  : i_ready_v[g];
      orv  = v.is_d ? i_rvalid_v[g] : d_rvalid_v[g];
      ordy = v.is_d ? i_ready_v[g]  : d_ready_v[g];
      if (orv || ordy) chk("wrong_side_strobe", {30'd0, orv, ordy}, 32'd0);
      if (is_rd) begin
        if (n < LW * (w + 1)) begin
          chk("rd_strobes", {30'd0, ce_n_v[g], oe_n_v[g]}, 32'd0);
          chk("rd_addr", 32'(sram_addr_v[g]), 32'(v.exp_base) + 32'(n / (w + 1)));
        end
        if (rvs) begin
          a = v.exp_base + AW'(rv);
          chk("rword", 32'(rword_v[g]), 32'(rv));
          chk("rdata", rdata_v[g], pat(a));
          chk("rvalid_time", 32'(n), 32'(w + 2 + rv * (w + 1)));
          rv++;
        end
      end else begin
        if (!we_n_v[g]) begin
          we_cnt++;
          if (we_cnt == 1) begin
            chk("wr_addr", 32'(sram_addr_v[g]), 32'(v.exp_base));
            chk("wr_data", sram_dq_o_v[g], v.wdata);
          end
        end
        if (dq_oe_v[g]) begin
          oe_cnt++;
          chk("wr_oe_n", {31'd0, oe_n_v[g]}, 32'd1);
        end
      end
      if (rdy) begin
        seen = 1'b1;
        chk("ready_latency", 32'(n), 32'(v.exp_ready));
        chk("rvalid_count", 32'(rv), 32'(v.exp_rv));
        if (!is_rd) begin
          chk("we_low_cycles", 32'(we_cnt), 32'(w + 1));
          chk("dq_oe_cycles", 32'(oe_cnt), 32'(w + 3));
        end
      end else begin
        @(posedge clk);
      end
    end
    if (!seen) timeout("txn_ready");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      rvs = v.is_d ? (d_rvalid_v[g] | d_ready_v[g]) : (i_rvalid_v[g] | i_ready_v[g]);
      chk("no_regrant", {30'd0, ce_n_v[g], rvs}, 32'd2);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (30) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt, m;
    bit  found, who;

    //          is_d  we    addr         wdata          inst rdy base         rv
    vecs[0] = '{1'b0, 1'b0, 18'h00013, 32'h0000_0000, 1, 10, 18'h00010, 4};
    vecs[1] = '{1'b1, 1'b1, 18'h0002A, 32'hDEAD_BEEF, 0,  4, 18'h0002A, 0};
    vecs[2] = '{1'b1, 1'b0, 18'h00105, 32'h0000_0000, 2, 18, 18'h00104, 4};
    vecs[3] = '{1'b1, 1'b1, 18'h3FFFF, 32'h1234_5678, 1,  5, 18'h3FFFF, 0};
    vecs[4] = '{1'b0, 1'b0, 18'h3FFFE, 32'h0000_0000, 0,  6, 18'h3FFFC, 4};
    vecs[5] = '{1'b1, 1'b1, 18'h00007, 32'hCAFE_F00D, 2,  7, 18'h00007, 0};
    vecs[6] = '{1'b0, 1'b0, 18'h00000, 32'h0000_0000, 2, 18, 18'h00000, 4};

    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset state of every instance
    for (int g = 0; g < 3; g++) begin
      chk("rst_strobes", {29'd0, ce_n_v[g], oe_n_v[g], we_n_v[g]}, 32'd7);
      chk("rst_dq_oe", {31'd0, dq_oe_v[g]}, 32'd0);
      chk("rst_addr", 32'(sram_addr_v[g]), 32'd0);
      chk("rst_rdata", rdata_v[g], 32'd0);
      chk("rst_rword", 32'(rword_v[g]), 32'd0);
      chk("rst_handshake",
          {28'd0, i_rvalid_v[g], i_ready_v[g], d_rvalid_v[g], d_ready_v[g]}, 32'd0);
    end

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset during the third word of a refill on the WAIT_CYCLES=1 instance
    @(negedge clk);
    i_addr = 18'h00013;
    i_req  = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_rdata", rdata_v[1], pat(18'h00010));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_strobes", {29'd0, ce_n_v[1], oe_n_v[1], we_n_v[1]}, 32'd7);
    chk("arst_addr", 32'(sram_addr_v[1]), 32'd0);
    chk("arst_rdata", rdata_v[1], 32'd0);
    chk("arst_rvalid", {31'd0, i_rvalid_v[1]}, 32'd0);
    i_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (i_ready_v[1] || d_ready_v[1]) cnt++;
    end
    chk("abort_no_ready", 32'(cnt), 32'd0);
    run_txn(vecs[0]);

    // Both requesters raised together and re-requesting after each ready: D, I, D, I
    @(negedge clk);
    d_we = 1'b1; d_addr = 18'h00055; d_wdata = 32'h0BAD_F00D; i_addr = 18'h00020;
    i_req = 1'b1; d_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      found = 1'b0; who = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(posedge clk); #1;
        if (i_ready_v[1] || d_ready_v[1]) begin
          found = 1'b1;
          who   = d_ready_v[1];
        end
      end
      if (!found) timeout("arb_ready");
      chk("arb_order", {31'd0, who}, (t % 2 == 0) ? 32'd1 : 32'd0);
      if (who) d_req = 1'b0; else i_req = 1'b0;
      @(posedge clk); #1;
      if (t < 3) begin
        if (who) d_req = 1'b1; else i_req = 1'b1;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (30) @(posedge clk);

    // d_req raised while the refill sits in HOLD: served only after i_req drops
    @(negedge clk);
    i_addr = 18'h00040; i_req = 1'b1;
    d_we = 1'b1; d_addr = 18'h00066; d_wdata = 32'h5555_AAAA;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if (i_ready_v[1]) found = 1'b1;
    end
    if (!found) timeout("hold_i_ready");
    d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("hold_no_grant", {30'd0, ce_n_v[1], d_ready_v[1]}, 32'd2);
    end
    i_req = 1'b0;
    m = 0;
    for (int k = 1; k <= 20 && m == 0; k++) begin
      @(posedge clk); #1;
      if (d_ready_v[1]) m = k;
    end
    chk("hold_d_latency", 32'(m), 32'd7);
    d_req = 1'b0;
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
